sampctl_seq: RTL



---
 rtl/sampctl_seq_if.sv | 52 +++++
 rtl/sampctl_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sampctl_seq_if.sv
// Sequencer-side bundle for sampctl_seq: start/parameter inputs and switch/status outputs.
// The optional `cont` signal exists only when SAMPCTL_SEQ_CONT_EN is defined.
interface sampctl_seq_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] samp_len;
   logic [CNT_W-1:0] gap_len;
   logic [NCH-1:0]   samp_p_en;
   logic [NCH-1:0]   samp_n_en;
`ifdef SAMPCTL_SEQ_CONT_EN
   logic             cont;
`endif
   logic             seq_samp;
   logic [NCH-1:0]   switch_p;
   logic [NCH-1:0]   switch_n;
   logic             busy;
   logic             done;

   modport master (
`ifdef SAMPCTL_SEQ_CONT_EN
      output cont,
`endif
      output start,
      output samp_len,
      output gap_len,
      output samp_p_en,
      output samp_n_en,
      input  seq_samp,
      input  switch_p,
      input  switch_n,
      input  busy,
      input  done
   );

   modport slave (
`ifdef SAMPCTL_SEQ_CONT_EN
      input  cont,
`endif
      input  start,
      input  samp_len,
      input  gap_len,
      input  samp_p_en,
      input  samp_n_en,
      output seq_samp,
      output switch_p,
      output switch_n,
      output busy,
      output done
   );
endinterface

// File: rtl/sampctl_seq.sv
// Sampling-switch sequencer: start -> SAMP window -> GAP (non-overlap) -> done pulse.
// Optional continuous re-run mode is enabled by defining SAMPCTL_SEQ_CONT_EN.
module sampctl_seq #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic          clk,
   input logic          rst,
   sampctl_seq_if.slave bus
);
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StSamp = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] samp_len_q, samp_len_d;
   logic [CNT_W-1:0] gap_len_q, gap_len_d;
   logic [NCH-1:0]   p_en_q, p_en_d;
   logic [NCH-1:0]   n_en_q, n_en_d;
   logic             restart_q, restart_d;
   logic             finish;

   logic             seq_samp_q, seq_samp_d;
   logic [NCH-1:0]   switch_p_q, switch_p_d;
   logic [NCH-1:0]   switch_n_q, switch_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      samp_len_d = samp_len_q;
      gap_len_d  = gap_len_q;
      p_en_d     = p_en_q;
      n_en_d     = n_en_q;
      restart_d  = 1'b0;
      finish     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (restart_q) begin
               // Re-run with the parameters latched by the original start.
               state_d = StSamp;
               cnt_d   = (samp_len_q == '0) ? '0 : samp_len_q - 1'b1;
            end else if (bus.start) begin
               state_d    = StSamp;
               samp_len_d = bus.samp_len;
               gap_len_d  = bus.gap_len;
               p_en_d     = bus.samp_p_en;
               n_en_d     = bus.samp_n_en;
               cnt_d      = (bus.samp_len == '0) ? '0 : bus.samp_len - 1'b1;
            end
         end
         StSamp: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (gap_len_q != '0) begin
               state_d = StGap;
               cnt_d   = gap_len_q - 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         StGap: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (finish) begin
         state_d = StIdle;
         cnt_d   = '0;
`ifdef SAMPCTL_SEQ_CONT_EN
         restart_d = bus.cont;
`endif
      end
   end

   // Outputs are registered from next-state values so they change with the state itself.
   always_comb begin
      seq_samp_d = (state_d == StSamp);
      switch_p_d = {NCH{seq_samp_d}} & p_en_d;
      switch_n_d = {NCH{seq_samp_d}} & n_en_d;
      busy_d     = (state_d != StIdle) | restart_d;
      done_d     = finish;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         samp_len_q <= '0;
         gap_len_q  <= '0;
         p_en_q     <= '0;
         n_en_q     <= '0;
         restart_q  <= 1'b0;
         seq_samp_q <= 1'b0;
         switch_p_q <= '0;
         switch_n_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         samp_len_q <= samp_len_d;
         gap_len_q  <= gap_len_d;
         p_en_q     <= p_en_d;
         n_en_q     <= n_en_d;
         restart_q  <= restart_d;
         seq_samp_q <= seq_samp_d;
         switch_p_q <= switch_p_d;
         switch_n_q <= switch_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.seq_samp = seq_samp_q;
   assign bus.switch_p = switch_p_q;
   assign bus.switch_n = switch_n_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
